// File: rtl/apb_bridge_pkg.sv
// Shared types for the APB width and clock bridges.
package apb_bridge_pkg;

   localparam int unsigned UP_DATA_WIDTH   = 64;
   localparam int unsigned DOWN_DATA_WIDTH = 32;
   localparam int unsigned UP_STRB_WIDTH   = UP_DATA_WIDTH / 8;
   localparam int unsigned DOWN_STRB_WIDTH = DOWN_DATA_WIDTH / 8;
   localparam int unsigned BEAT_OFFSET     = DOWN_STRB_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LO_SETUP  = 3'd1,
      ST_LO_ACCESS = 3'd2,
      ST_HI_SETUP  = 3'd3,
      ST_HI_ACCESS = 3'd4,
      ST_RESP      = 3'd5
   } apb_bridge_state_e;

   // Upstream request captured at accept time.
   typedef struct packed {
      logic                     write;
      logic [UP_DATA_WIDTH-1:0] wdata;
      logic [UP_STRB_WIDTH-1:0] strb;
   } up_req_t;

   function automatic logic beat_empty(input logic [DOWN_STRB_WIDTH-1:0] strb);
      return strb == '0;
   endfunction

endpackage

// File: rtl/apb_x64_to_x32_bridge_if.sv
// APB bus bundle; the requester side also forwards clock and reset downstream.
interface apb_x64_to_x32_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  pclk;
   logic                  preset_n;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [STRB_WIDTH-1:0] pstrb;
   logic [2:0]            pprot;
   logic                  pwakeup;
   logic                  pauser;
   logic                  pwuser;
   logic                  pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pslverr;

   modport completer (
      input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata, pstrb,
             pprot, pwakeup, pauser, pwuser,
      output pready, prdata, pslverr
   );

   modport requester (
      output pclk, preset_n, psel, penable, pwrite, paddr, pwdata, pstrb,
             pprot, pwakeup, pauser, pwuser,
      input  pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_x64_to_x32_bridge.sv
// Splits each 64-bit APB transfer into low/high 32-bit APB beats and merges
// the responses back into one 64-bit completion.
module apb_x64_to_x32_bridge
   import apb_bridge_pkg::*;
#(
   parameter bit SKIP_EMPTY_STROBE = 1'b1,
   parameter bit ABORT_ON_ERROR    = 1'b1
) (
   apb_x64_to_x32_bridge_if.completer apb_up,
   apb_x64_to_x32_bridge_if.requester apb_down
);

   localparam int unsigned AW = $bits(apb_up.paddr);

   if ($bits(apb_up.pwdata) != UP_DATA_WIDTH) begin : g_up_width_check
      $error("apb_up DATA_WIDTH must be 64");
   end
   if ($bits(apb_down.pwdata) != DOWN_DATA_WIDTH) begin : g_down_width_check
      $error("apb_down DATA_WIDTH must be 32");
   end
   if ($bits(apb_up.paddr) != $bits(apb_down.paddr)) begin : g_addr_width_check
      $error("apb_up and apb_down ADDR_WIDTH must match");
   end

   logic clk;
   logic rst_n;

   assign clk   = apb_up.pclk;
   assign rst_n = apb_up.preset_n;

   assign apb_down.pclk     = apb_up.pclk;
   assign apb_down.preset_n = apb_up.preset_n;
   assign apb_down.pprot    = '0;
   assign apb_down.pwakeup  = 1'b0;
   assign apb_down.pauser   = 1'b0;
   assign apb_down.pwuser   = 1'b0;

   apb_bridge_state_e            state_q, state_d;
   logic [AW-1:0]                addr_q, addr_d;
   up_req_t                      req_q, req_d;
   logic [UP_DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic                         err_q, err_d;

   logic                         up_pready_q, up_pready_d;
   logic [UP_DATA_WIDTH-1:0]     up_prdata_q, up_prdata_d;
   logic                         up_pslverr_q, up_pslverr_d;
   logic                         dn_psel_q, dn_psel_d;
   logic                         dn_penable_q, dn_penable_d;
   logic                         dn_pwrite_q, dn_pwrite_d;
   logic [AW-1:0]                dn_paddr_q, dn_paddr_d;
   logic [DOWN_DATA_WIDTH-1:0]   dn_pwdata_q, dn_pwdata_d;
   logic [DOWN_STRB_WIDTH-1:0]   dn_pstrb_q, dn_pstrb_d;

   logic [AW-1:0]                src_addr;
   up_req_t                      src_req;
   logic                         start_lo;
   logic                         start_hi;
   logic                         go_resp;

   // Next-state and next-output decode; beat launches draw on the fresh
   // request in IDLE and on the latched one afterwards.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      req_d        = req_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      up_pready_d  = 1'b0;
      up_prdata_d  = '0;
      up_pslverr_d = 1'b0;
      dn_psel_d    = dn_psel_q;
      dn_penable_d = dn_penable_q;
      dn_pwrite_d  = dn_pwrite_q;
      dn_paddr_d   = dn_paddr_q;
      dn_pwdata_d  = dn_pwdata_q;
      dn_pstrb_d   = dn_pstrb_q;
      src_addr     = addr_q;
      src_req      = req_q;
      start_lo     = 1'b0;
      start_hi     = 1'b0;
      go_resp      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (apb_up.psel && !apb_up.penable) begin
               src_addr = apb_up.paddr;
               src_req  = '{write: apb_up.pwrite, wdata: apb_up.pwdata, strb: apb_up.pstrb};
               addr_d   = src_addr;
               req_d    = src_req;
               rdata_d  = '0;
               err_d    = 1'b0;
               if (src_addr[2:0] != 3'b000) begin
                  err_d   = 1'b1;
                  go_resp = 1'b1;
               end else if (src_req.write && (src_req.strb == '0)) begin
                  go_resp = 1'b1;
               end else if (src_req.write && SKIP_EMPTY_STROBE &&
                            beat_empty(src_req.strb[DOWN_STRB_WIDTH-1:0])) begin
                  start_hi = 1'b1;
               end else begin
                  start_lo = 1'b1;
               end
            end
         end
         ST_LO_SETUP: begin
            state_d      = ST_LO_ACCESS;
            dn_penable_d = 1'b1;
         end
         ST_LO_ACCESS: begin
            if (apb_down.pready) begin
               if (!req_q.write) rdata_d[DOWN_DATA_WIDTH-1:0] = apb_down.prdata;
               err_d = err_q | apb_down.pslverr;
               if (ABORT_ON_ERROR && apb_down.pslverr) begin
                  go_resp = 1'b1;
               end else if (req_q.write && SKIP_EMPTY_STROBE &&
                            beat_empty(req_q.strb[UP_STRB_WIDTH-1:DOWN_STRB_WIDTH])) begin
                  go_resp = 1'b1;
               end else begin
                  start_hi = 1'b1;
               end
            end
         end
         ST_HI_SETUP: begin
            state_d      = ST_HI_ACCESS;
            dn_penable_d = 1'b1;
         end
         ST_HI_ACCESS: begin
            if (apb_down.pready) begin
               if (!req_q.write) rdata_d[UP_DATA_WIDTH-1:DOWN_DATA_WIDTH] = apb_down.prdata;
               err_d   = err_q | apb_down.pslverr;
               go_resp = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_lo) begin
         state_d      = ST_LO_SETUP;
         dn_psel_d    = 1'b1;
         dn_penable_d = 1'b0;
         dn_pwrite_d  = src_req.write;
         dn_paddr_d   = src_addr;
         dn_pwdata_d  = src_req.wdata[DOWN_DATA_WIDTH-1:0];
         dn_pstrb_d   = src_req.strb[DOWN_STRB_WIDTH-1:0];
      end

      // High-beat address wraps at AW bits.
      if (start_hi) begin
         state_d      = ST_HI_SETUP;
         dn_psel_d    = 1'b1;
         dn_penable_d = 1'b0;
         dn_pwrite_d  = src_req.write;
         dn_paddr_d   = AW'(src_addr + AW'(BEAT_OFFSET));
         dn_pwdata_d  = src_req.wdata[UP_DATA_WIDTH-1:DOWN_DATA_WIDTH];
         dn_pstrb_d   = src_req.strb[UP_STRB_WIDTH-1:DOWN_STRB_WIDTH];
      end

      if (go_resp) begin
         state_d      = ST_RESP;
         dn_psel_d    = 1'b0;
         dn_penable_d = 1'b0;
         up_pready_d  = 1'b1;
         up_pslverr_d = err_d;
         up_prdata_d  = req_d.write ? '0 : rdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         req_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         up_pready_q  <= 1'b0;
         up_prdata_q  <= '0;
         up_pslverr_q <= 1'b0;
         dn_psel_q    <= 1'b0;
         dn_penable_q <= 1'b0;
         dn_pwrite_q  <= 1'b0;
         dn_paddr_q   <= '0;
         dn_pwdata_q  <= '0;
         dn_pstrb_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         up_pready_q  <= up_pready_d;
         up_prdata_q  <= up_prdata_d;
         up_pslverr_q <= up_pslverr_d;
         dn_psel_q    <= dn_psel_d;
         dn_penable_q <= dn_penable_d;
         dn_pwrite_q  <= dn_pwrite_d;
         dn_paddr_q   <= dn_paddr_d;
         dn_pwdata_q  <= dn_pwdata_d;
         dn_pstrb_q   <= dn_pstrb_d;
      end
   end

   assign apb_up.pready    = up_pready_q;
   assign apb_up.prdata    = up_prdata_q;
   assign apb_up.pslverr   = up_pslverr_q;
   assign apb_down.psel    = dn_psel_q;
   assign apb_down.penable = dn_penable_q;
   assign apb_down.pwrite  = dn_pwrite_q;
   assign apb_down.paddr   = dn_paddr_q;
   assign apb_down.pwdata  = dn_pwdata_q;
   assign apb_down.pstrb   = dn_pstrb_q;

endmodule

// File: tb/tb_apb_x64_to_x32_bridge.sv
// Bench for apb_x64_to_x32_bridge: directed plan items plus random transfers
// against a transaction-level model of the split/merge rules.
module tb_apb_x64_to_x32_bridge;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } beat_t;

   apb_x64_to_x32_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) up_if ();
   apb_x64_to_x32_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dn_if ();

   apb_x64_to_x32_bridge #(
      .SKIP_EMPTY_STROBE (1'b1),
      .ABORT_ON_ERROR    (1'b1)
   ) dut (
      .apb_up   (up_if),
      .apb_down (dn_if)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Downstream completer configuration, indexed 0 = low word, 1 = high word.
   logic [31:0] cfg_rdata [2];
   int          cfg_waits [2];
   logic        cfg_err   [2];
   beat_t       seen_q[$];
   int          wait_cnt;

   beat_t       exp_q[$];
   logic [63:0] exp_rdata;
   logic        exp_err;
   int          exp_lat;

   initial begin
      up_if.pclk = 1'b0;
      forever #5 up_if.pclk = ~up_if.pclk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Downstream completer: logs each setup phase, then answers after cfg waits.
   initial begin
      int idx;
      dn_if.pready  = 1'b0;
      dn_if.prdata  = '0;
      dn_if.pslverr = 1'b0;
      wait_cnt      = 0;
      forever begin
         @(negedge up_if.pclk);
         if (dn_if.psel && !dn_if.penable) begin
            seen_q.push_back(beat_t'{addr: dn_if.paddr, write: dn_if.pwrite,
                                     wdata: dn_if.pwdata, strb: dn_if.pstrb});
            wait_cnt      = 0;
            dn_if.pready  = 1'b0;
            dn_if.prdata  = '0;
            dn_if.pslverr = 1'b0;
         end else if (dn_if.psel && dn_if.penable) begin
            idx = dn_if.paddr[2] ? 1 : 0;
            if (wait_cnt < cfg_waits[idx]) begin
               wait_cnt++;
               dn_if.pready = 1'b0;
            end else begin
               dn_if.pready  = 1'b1;
               dn_if.prdata  = cfg_rdata[idx];
               dn_if.pslverr = cfg_err[idx];
            end
         end else begin
            dn_if.pready  = 1'b0;
            dn_if.prdata  = '0;
            dn_if.pslverr = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction-level expectation: which beats appear, merged data/error, latency.
   task automatic predict(input logic [31:0] a, input logic w, input logic [63:0] wd,
                          input logic [7:0] s);
      logic do_lo, do_hi, lo_err;
      exp_q.delete();
      exp_rdata = '0;
      exp_err   = 1'b0;
      exp_lat   = 1;
      if (a[2:0] != 3'b000) begin
         exp_err = 1'b1;
         return;
      end
      if (w && s == 8'h00) return;
      do_lo  = !(w && s[3:0] == 4'h0);
      lo_err = do_lo && cfg_err[0];
      do_hi  = !(w && s[7:4] == 4'h0) && !lo_err;
      if (do_lo) begin
         exp_q.push_back(beat_t'{addr: a, write: w, wdata: wd[31:0], strb: s[3:0]});
         exp_lat += 2 + cfg_waits[0];
         exp_err |= cfg_err[0];
         if (!w) exp_rdata[31:0] = cfg_rdata[0];
      end
      if (do_hi) begin
         exp_q.push_back(beat_t'{addr: a + 32'd4, write: w, wdata: wd[63:32], strb: s[7:4]});
         exp_lat += 2 + cfg_waits[1];
         exp_err |= cfg_err[1];
         if (!w) exp_rdata[63:32] = cfg_rdata[1];
      end
   endtask

   task automatic do_xfer(input string tag, input logic [31:0] a, input logic w,
                          input logic [63:0] wd, input logic [7:0] s, input bit drop);
      int          cyc;
      logic        done;
      logic [63:0] got_data;
      logic        got_err;
      predict(a, w, wd, s);
      @(negedge up_if.pclk);
      seen_q.delete();
      up_if.psel    = 1'b1;
      up_if.penable = 1'b0;
      up_if.paddr   = a;
      up_if.pwrite  = w;
      up_if.pwdata  = wd;
      up_if.pstrb   = s;
      @(posedge up_if.pclk);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 64) begin
         @(negedge up_if.pclk);
         cyc++;
         up_if.penable = 1'b1;
         if (drop && cyc == 2) up_if.psel = 1'b0;
         if (up_if.pready) done = 1'b1;
      end
      got_data = up_if.prdata;
      got_err  = up_if.pslverr;
      if (done) @(posedge up_if.pclk);
      @(negedge up_if.pclk);
      up_if.psel    = 1'b0;
      up_if.penable = 1'b0;
      check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
      check({tag, "_prdata"}, 128'(got_data), 128'(exp_rdata));
      check({tag, "_pslverr"}, 128'(got_err), 128'(exp_err));
      check({tag, "_nbeats"}, 128'(seen_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_beat%0d", tag, i),
               (i < seen_q.size()) ? 128'(seen_q[i]) : 128'd0, 128'(exp_q[i]));
      end
   endtask

   task automatic set_cfg(input logic [31:0] rlo, input logic [31:0] rhi,
                          input int wlo, input int whi, input logic elo, input logic ehi);
      cfg_rdata[0] = rlo; cfg_rdata[1] = rhi;
      cfg_waits[0] = wlo; cfg_waits[1] = whi;
      cfg_err[0]   = elo; cfg_err[1]   = ehi;
   endtask

   function automatic logic [127:0] all_outputs();
      return 128'({up_if.pready, up_if.prdata, up_if.pslverr, dn_if.psel, dn_if.penable,
                   dn_if.pwrite, dn_if.paddr, dn_if.pwdata, dn_if.pstrb});
   endfunction

   initial begin
      logic [31:0] a;
      logic        w;
      logic [63:0] wd;
      logic [7:0]  s;
      int          cyc;
      logic        saw_ready;

      up_if.preset_n = 1'b0;
      up_if.psel     = 1'b0;
      up_if.penable  = 1'b0;
      up_if.pwrite   = 1'b0;
      up_if.paddr    = '0;
      up_if.pwdata   = '0;
      up_if.pstrb    = '0;
      up_if.pprot    = '0;
      up_if.pwakeup  = 1'b0;
      up_if.pauser   = 1'b0;
      up_if.pwuser   = 1'b0;
      set_cfg(32'h0, 32'h0, 0, 0, 1'b0, 1'b0);

      repeat (3) @(negedge up_if.pclk);
      check("reset_outputs", all_outputs(), 128'd0);
      up_if.preset_n = 1'b1;
      check("tieoffs", 128'({dn_if.pprot, dn_if.pwakeup, dn_if.pauser, dn_if.pwuser}), 128'd0);

      set_cfg(32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
      do_xfer("aligned_write", 32'h0080_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1'b0);

      set_cfg(32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 2, 1'b0, 1'b0);
      do_xfer("read_wait", 32'h0080_0020, 1'b0, 64'h0, 8'h00, 1'b0);
      check("read_wait_literal", 128'(up_if.prdata === 64'h0 ? exp_rdata : 64'h0),
            128'(64'hCAFE_F00D_DEAD_BEEF));

      set_cfg(32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
      do_xfer("strobe_skip_lo", 32'h0080_0030, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 1'b0);
      do_xfer("strobe_skip_hi", 32'h0080_0038, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'h0F, 1'b0);
      do_xfer("zero_strobe", 32'h0080_0040, 1'b1, 64'h1, 8'h00, 1'b0);

      set_cfg(32'h1111_2222, 32'h3333_4444, 1, 0, 1'b1, 1'b0);
      do_xfer("lo_error", 32'h0080_0048, 1'b0, 64'h0, 8'h00, 1'b0);

      set_cfg(32'h5555_6666, 32'h7777_8888, 0, 1, 1'b0, 1'b1);
      do_xfer("hi_error", 32'h0080_0050, 1'b0, 64'h0, 8'h00, 1'b0);

      do_xfer("misaligned", 32'h0080_0004, 1'b0, 64'h0, 8'h00, 1'b0);

      set_cfg(32'h0BAD_F00D, 32'h600D_CAFE, 0, 0, 1'b0, 1'b0);
      do_xfer("addr_top", 32'hFFFF_FFF8, 1'b0, 64'h0, 8'h00, 1'b0);

      // Reset asserted while the high beat is waiting downstream.
      set_cfg(32'h1, 32'h2, 0, 4, 1'b0, 1'b0);
      @(negedge up_if.pclk);
      seen_q.delete();
      up_if.psel    = 1'b1;
      up_if.penable = 1'b0;
      up_if.paddr   = 32'h0080_0060;
      up_if.pwrite  = 1'b0;
      @(posedge up_if.pclk);
      @(negedge up_if.pclk);
      up_if.penable = 1'b1;
      cyc       = 0;
      saw_ready = 1'b0;
      while (!(dn_if.psel && dn_if.penable && dn_if.paddr[2]) && cyc < 32) begin
         @(negedge up_if.pclk);
         cyc++;
         if (up_if.pready) saw_ready = 1'b1;
      end
      check("rst_reached_hi_access", 128'(cyc < 32), 128'd1);
      #1;
      up_if.preset_n = 1'b0;
      up_if.psel     = 1'b0;
      up_if.penable  = 1'b0;
      #1;
      check("rst_outputs_immediate", all_outputs(), 128'd0);
      repeat (2) begin
         @(negedge up_if.pclk);
         if (up_if.pready) saw_ready = 1'b1;
      end
      check("rst_no_pready", 128'(saw_ready), 128'd0);
      up_if.preset_n = 1'b1;
      set_cfg(32'hA5A5_0001, 32'h5A5A_0002, 0, 0, 1'b0, 1'b0);
      do_xfer("after_reset", 32'h0080_0068, 1'b0, 64'h0, 8'h00, 1'b0);

      for (int t = 0; t < 40; t++) begin
         a = 32'h0080_0000 | (32'($urandom_range(0, 1023)) << 3);
         if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
         w  = 1'($urandom_range(0, 1));
         wd = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0:       s = 8'hFF;
            1:       s = 8'h0F;
            2:       s = 8'hF0;
            3:       s = 8'h00;
            default: s = 8'($urandom);
         endcase
         set_cfg($urandom, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         do_xfer($sformatf("rand%0d", t), a, w, wd, s, $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
